// File: rtl/axi_spm_responder.sv
// axi_spm_responder: AXI4 scratchpad subordinate with independent single-outstanding read and write burst engines
package axi_spm_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
    } axi_narrow_aw_chan_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_narrow_ar_chan_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_narrow_w_chan_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_narrow_b_chan_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_narrow_r_chan_t;
    typedef struct packed {
        axi_narrow_aw_chan_t aw;
        logic                aw_valid;
        axi_narrow_w_chan_t  w;
        logic                w_valid;
        logic                b_ready;
        axi_narrow_ar_chan_t ar;
        logic                ar_valid;
        logic                r_ready;
    } axi_narrow_out_req_t;
    typedef struct packed {
        logic               aw_ready;
        logic               w_ready;
        axi_narrow_b_chan_t b;
        logic               b_valid;
        logic               ar_ready;
        axi_narrow_r_chan_t r;
        logic               r_valid;
    } axi_narrow_out_rsp_t;
endpackage

module axi_spm_responder
    import axi_spm_pkg::*;
#(
    parameter int unsigned           AddrWidth = 48,
    parameter int unsigned           DataWidth = 64,
    parameter int unsigned           IdWidth   = 4,
    parameter int unsigned           MemWords  = 1024,
    parameter logic [AddrWidth-1:0]  BaseAddr  = '0,
    parameter type                   axi_req_t = axi_narrow_out_req_t,
    parameter type                   axi_rsp_t = axi_narrow_out_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);
    localparam int NB   = DataWidth / 8;
    localparam int OffB = $clog2(NB);
    localparam int IdxW = $clog2(MemWords);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic out_of_range(input logic [AddrWidth-1:0] a);
        return (a < BaseAddr) || (((a - BaseAddr) >> OffB) >= AddrWidth'(MemWords));
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] a);
        return IdxW'((a - BaseAddr) >> OffB);
    endfunction

    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'(OffB)) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    // WRAP bursts fold back to the boundary-aligned base once the next address leaves the wrap window
    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a, input logic [7:0] len,
                                                       input logic [2:0] size, input logic [1:0] burst);
        logic [AddrWidth-1:0] bnd, lo, n;
        bnd = AddrWidth'({1'b0, len} + 9'd1) << size;
        lo  = a & ~(bnd - 1'b1);
        n   = a + (AddrWidth'(1) << size);
        return (burst == 2'b00) ? a : ((burst == 2'b10) && (n >= lo + bnd)) ? lo : n;
    endfunction

    logic [DataWidth-1:0] mem [MemWords];

    w_state_t             w_state, w_state_n;
    logic [IdWidth-1:0]   w_id;
    logic [AddrWidth-1:0] w_addr;
    logic [7:0]           w_len, w_cnt;
    logic [2:0]           w_size;
    logic [1:0]           w_burst;
    logic [5:0]           w_atop;
    logic                 w_err, w_inh;

    r_state_t             r_state, r_state_n;
    logic [IdWidth-1:0]   r_id;
    logic [AddrWidth-1:0] r_addr;
    logic [7:0]           r_len, r_cnt;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic [DataWidth-1:0] r_data;
    logic                 r_slv;

    logic aw_hs, w_hs, w_final, w_mism, w_oor, w_bad, w_we;
    logic ar_hs, r_hs, r_final, r_adv, ld_err;
    logic [AddrWidth-1:0] ld_addr;

    assign aw_hs   = axi_req_i.aw_valid && (w_state == W_IDLE);
    assign w_hs    = axi_req_i.w_valid && (w_state == W_DATA);
    assign w_final = (w_cnt == w_len);
    assign w_mism  = axi_req_i.w.last != w_final;
    assign w_oor   = out_of_range(w_addr);
    assign w_bad   = burst_bad(w_len, w_size, w_burst) || (w_atop != '0);
    assign w_we    = w_hs && !(w_bad || w_inh || w_mism || w_oor);

    assign ar_hs   = axi_req_i.ar_valid && (r_state == R_IDLE);
    assign r_hs    = axi_req_i.r_ready && (r_state == R_DATA);
    assign r_final = (r_cnt == r_len);
    assign r_adv   = r_hs && !r_final;
    assign ld_addr = ar_hs ? axi_req_i.ar.addr : next_addr(r_addr, r_len, r_size, r_burst);
    assign ld_err  = (ar_hs ? burst_bad(axi_req_i.ar.len, axi_req_i.ar.size, axi_req_i.ar.burst)
                            : burst_bad(r_len, r_size, r_burst)) || out_of_range(ld_addr);

    // State registers for both burst engines
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
        end
    end

    // Write engine: address phase, counted data beats, then response
    always_comb begin
        w_state_n = w_state;
        w_state_n = (w_state == W_IDLE) ? (axi_req_i.aw_valid ? W_DATA : W_IDLE)
                  : (w_state == W_DATA) ? ((w_hs && w_final) ? W_RESP : W_DATA)
                  : (axi_req_i.b_ready ? W_IDLE : W_RESP);
    end

    // Read engine: stays in R_DATA until the last beat is accepted
    always_comb begin
        r_state_n = r_state;
        r_state_n = (r_state == R_IDLE) ? (axi_req_i.ar_valid ? R_DATA : R_IDLE)
                  : ((r_hs && r_final) ? R_IDLE : R_DATA);
    end

    // Write burst context; a wlast mismatch poisons the rest of the burst, a stray beat only flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_atop  <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_inh   <= 1'b0;
        end else begin
            if (aw_hs) begin
                w_id    <= axi_req_i.aw.id;
                w_addr  <= axi_req_i.aw.addr;
                w_len   <= axi_req_i.aw.len;
                w_size  <= axi_req_i.aw.size;
                w_burst <= axi_req_i.aw.burst;
                w_atop  <= axi_req_i.aw.atop;
                w_cnt   <= '0;
                w_err   <= 1'b0;
                w_inh   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                w_inh  <= w_inh | w_mism;
                w_err  <= w_err | w_mism | w_oor;
            end
        end
    end

    // Byte-strobed storage write; contents are intentionally not reset
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int b = 0; b < NB; b++) begin
                if (axi_req_i.w.strb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
        end
    end

    // Read burst context; r_data is preloaded so a stalled beat holds its fields
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_slv   <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= axi_req_i.ar.id;
                r_addr  <= axi_req_i.ar.addr;
                r_len   <= axi_req_i.ar.len;
                r_size  <= axi_req_i.ar.size;
                r_burst <= axi_req_i.ar.burst;
                r_cnt   <= '0;
            end
            if (r_adv) begin
                r_addr <= ld_addr;
                r_cnt  <= r_cnt + 8'd1;
            end
            if (ar_hs || r_adv) begin
                r_data <= ld_err ? '0 : mem[word_idx(ld_addr)];
                r_slv  <= ld_err;
            end
        end
    end

    // Response assembly; readys are masked while reset is asserted
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = (w_state == W_IDLE) && !rst_i;
        axi_rsp_o.w_ready  = (w_state == W_DATA);
        axi_rsp_o.b_valid  = (w_state == W_RESP);
        axi_rsp_o.b.id     = w_id;
        axi_rsp_o.b.resp   = {w_err | w_bad, 1'b0};
        axi_rsp_o.ar_ready = (r_state == R_IDLE) && !rst_i;
        axi_rsp_o.r_valid  = (r_state == R_DATA);
        axi_rsp_o.r.id     = r_id;
        axi_rsp_o.r.data   = r_data;
        axi_rsp_o.r.resp   = {r_slv, 1'b0};
        axi_rsp_o.r.last   = (r_state == R_DATA) && r_final;
    end
endmodule

// File: tb/tb_axi_spm_responder.sv
// tb_axi_spm_responder: directed and randomized bursts checked against a word-array reference model
module tb_axi_spm_responder;
    import axi_spm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    axi_narrow_out_req_t req;
    axi_narrow_out_rsp_t rsp;
    int vectors = 0;
    int miscompares = 0;
    logic [63:0] mdl [1024];
    logic [63:0] wd [256];
    logic [7:0]  wst [256];
    logic [63:0] last_rd;
    time aw_t, ar_t;

    axi_spm_responder dut (
        .clk_i(clk),
        .rst_i(rst),
        .axi_req_i(req),
        .axi_rsp_o(rsp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic mbad(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        return size > 3 || burst == 3 || (burst == 2 && len != 1 && len != 3 && len != 7 && len != 15);
    endfunction

    function automatic logic moor(input logic [47:0] a);
        return a >= 48'h2000;
    endfunction

    function automatic logic [47:0] beat_addr(input logic [47:0] s, input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst, input int i);
        longint step, bnd, lo;
        step = longint'(1) << size;
        bnd  = (longint'(len) + 1) * step;
        lo   = longint'(s) - (longint'(s) % bnd);
        if (burst == 0) return s;
        if (burst == 2) return 48'(lo + ((longint'(s) - lo + i * step) % bnd));
        return 48'(longint'(s) + i * step);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [47:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] atop, input int bad_last);
        logic [3:0] id;
        logic err, inh;
        logic [47:0] ba;
        int n;
        id = 4'($urandom);
        @(negedge clk);
        req.aw.id = id;
        req.aw.addr = a;
        req.aw.len = len;
        req.aw.size = size;
        req.aw.burst = burst;
        req.aw.atop = atop;
        req.aw_valid = 1'b1;
        n = 0;
        while (rsp.aw_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("aw_ready", 64'(rsp.aw_ready), 1);
        @(posedge clk);
        aw_t = $time;
        @(negedge clk);
        req.aw_valid = 1'b0;
        chk("w_ready_latency", 64'(rsp.w_ready), 1);
        for (int i = 0; i <= int'(len); i++) begin
            req.w.data = wd[i];
            req.w.strb = wst[i];
            req.w.last = (i == int'(len)) ^ (i == bad_last);
            req.w_valid = 1'b1;
            chk("w_ready", 64'(rsp.w_ready), 1);
            @(posedge clk);
            @(negedge clk);
        end
        req.w_valid = 1'b0;
        err = mbad(len, size, burst) || atop != 0;
        inh = err;
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, len, size, burst, i);
            if (i == bad_last) begin
                err = 1'b1;
                inh = 1'b1;
            end
            if (moor(ba)) err = 1'b1;
            else if (!inh)
                for (int b = 0; b < 8; b++)
                    if (wst[i][b]) mdl[ba[12:3]][8*b +: 8] = wd[i][8*b +: 8];
        end
        chk("b_valid", 64'(rsp.b_valid), 1);
        chk("b_id", 64'(rsp.b.id), 64'(id));
        chk("b_resp", 64'(rsp.b.resp), err ? 2 : 0);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            @(negedge clk);
            chk("b_hold", 64'(rsp.b_valid), 1);
        end
        req.b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.b_ready = 1'b0;
        chk("b_done", 64'(rsp.b_valid), 0);
        chk("aw_ready_back", 64'(rsp.aw_ready), 1);
    endtask

    // mode 0: r_ready always high, 1: toggles 1010..., 2: random
    task automatic do_read(input logic [47:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode);
        logic [63:0] ed [256];
        logic [1:0] er [256];
        logic [47:0] ba;
        logic [3:0] id;
        logic rdy, tog;
        int n, stalls;
        id = 4'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, len, size, burst, i);
            if (mbad(len, size, burst) || moor(ba)) begin
                ed[i] = '0;
                er[i] = 2'b10;
            end else begin
                ed[i] = mdl[ba[12:3]];
                er[i] = 2'b00;
            end
        end
        @(negedge clk);
        req.ar.id = id;
        req.ar.addr = a;
        req.ar.len = len;
        req.ar.size = size;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
        req.r_ready = 1'b0;
        n = 0;
        while (rsp.ar_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ar_ready", 64'(rsp.ar_ready), 1);
        @(posedge clk);
        ar_t = $time;
        @(negedge clk);
        req.ar_valid = 1'b0;
        last_rd = rsp.r.data;
        tog = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            rdy = 1'b0;
            stalls = 0;
            while (!rdy) begin
                chk("r_valid", 64'(rsp.r_valid), 1);
                chk("r_id", 64'(rsp.r.id), 64'(id));
                chk("r_data", rsp.r.data, ed[i]);
                chk("r_resp", 64'(rsp.r.resp), 64'(er[i]));
                chk("r_last", 64'(rsp.r.last), (i == int'(len)) ? 1 : 0);
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom);
                tog = ~tog;
                if (stalls >= 3) rdy = 1'b1;
                stalls++;
                req.r_ready = rdy;
                @(posedge clk);
                @(negedge clk);
            end
        end
        req.r_ready = 1'b0;
        chk("r_done", 64'(rsp.r_valid), 0);
        chk("ar_ready_back", 64'(rsp.ar_ready), 1);
    endtask

    initial begin
        logic [2:0] sz;
        logic [1:0] bu;
        logic [7:0] ln;
        logic [47:0] ad;
        req = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_aw_ready", 64'(rsp.aw_ready), 0);
        chk("rst_ar_ready", 64'(rsp.ar_ready), 0);
        chk("rst_w_ready", 64'(rsp.w_ready), 0);
        chk("rst_b_valid", 64'(rsp.b_valid), 0);
        chk("rst_r_valid", 64'(rsp.r_valid), 0);
        chk("rst_r_data", rsp.r.data, 0);
        chk("rst_r_resp", 64'(rsp.r.resp), 0);
        chk("rst_b_resp", 64'(rsp.b.resp), 0);
        chk("rst_ids", 64'({rsp.r.id, rsp.b.id}), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_aw_ready", 64'(rsp.aw_ready), 1);
        chk("post_rst_ar_ready", 64'(rsp.ar_ready), 1);

        for (int i = 0; i < 64; i++) begin
            wd[i] = {$urandom, $urandom};
            wst[i] = 8'hFF;
        end
        do_write(48'h0, 8'd63, 3'd3, 2'd1, 6'd0, -1);

        wd[0] = 64'hDEADBEEF_CAFEF00D;
        wst[0] = 8'hFF;
        do_write(48'h10, 8'd0, 3'd3, 2'd1, 6'd0, -1);
        do_read(48'h10, 8'd0, 3'd3, 2'd1, 0);
        chk("single_rd", last_rd, 64'hDEADBEEF_CAFEF00D);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 64'(i + 1);
            wst[i] = 8'hFF;
        end
        do_write(48'h0, 8'd3, 3'd3, 2'd1, 6'd0, -1);
        do_read(48'h0, 8'd3, 3'd3, 2'd1, 1);

        wd[0] = 64'h11111111_11111111;
        wst[0] = 8'hFF;
        do_write(48'h30, 8'd0, 3'd3, 2'd1, 6'd0, -1);
        wd[0] = 64'hAAAAAAAA_AAAAAAAA;
        wst[0] = 8'h0F;
        do_write(48'h30, 8'd0, 3'd3, 2'd1, 6'd0, -1);
        do_read(48'h30, 8'd0, 3'd3, 2'd1, 0);
        chk("strb_merge", last_rd, 64'h11111111_AAAAAAAA);
        do_read(48'h28, 8'd3, 3'd3, 2'd2, 2);

        wd[0] = 64'h0BAD0BAD_0BAD0BAD;
        wst[0] = 8'hFF;
        do_write(48'h2000, 8'd0, 3'd3, 2'd1, 6'd0, -1);
        do_read(48'h0, 8'd0, 3'd3, 2'd1, 0);
        do_write(48'h40, 8'd0, 3'd4, 2'd1, 6'd0, -1);
        do_read(48'h40, 8'd0, 3'd3, 2'd1, 0);
        do_write(48'h48, 8'd0, 3'd3, 2'd1, 6'h20, -1);
        do_read(48'h48, 8'd0, 3'd3, 2'd1, 0);
        wd[0] = mdl[16];
        for (int i = 1; i < 4; i++) begin
            wd[i] = {$urandom, $urandom};
            wst[i] = 8'hFF;
        end
        do_write(48'h80, 8'd3, 3'd3, 2'd1, 6'd0, 1);
        do_read(48'h80, 8'd3, 3'd3, 2'd1, 0);
        do_read(48'h2000, 8'd2, 3'd3, 2'd1, 2);

        wd[0] = 64'h01234567_89ABCDEF;
        wst[0] = 8'hFF;
        fork
            do_write(48'h100, 8'd0, 3'd3, 2'd1, 6'd0, -1);
            do_read(48'h100, 8'd1, 3'd3, 2'd0, 0);
        join
        chk("aw_ar_same_cycle", 64'(aw_t), 64'(ar_t));
        do_read(48'h100, 8'd0, 3'd3, 2'd1, 0);
        chk("conflict_new", last_rd, 64'h01234567_89ABCDEF);

        for (int k = 0; k < 40; k++) begin
            bu = 2'($urandom_range(0, 2));
            sz = 3'($urandom_range(0, 3));
            ln = (bu == 2) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 7));
            ad = 48'($urandom_range(0, 55) * 8) + (48'($urandom_range(0, 7)) & ~((48'd1 << sz) - 1));
            if ($urandom_range(0, 9) == 0) ad = ad + 48'h2000;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wd[i] = {$urandom, $urandom};
                    wst[i] = 8'($urandom);
                end
                do_write(ad, ln, sz, bu, 6'd0, -1);
            end else begin
                do_read(ad, ln, sz, bu, 2);
            end
        end

        @(negedge clk);
        req.aw.id = 4'd1;
        req.aw.addr = 48'h200;
        req.aw.len = 8'd7;
        req.aw.size = 3'd3;
        req.aw.burst = 2'd1;
        req.aw.atop = 6'd0;
        req.aw_valid = 1'b1;
        req.ar.id = 4'd2;
        req.ar.addr = 48'h200;
        req.ar.len = 8'd7;
        req.ar.size = 3'd3;
        req.ar.burst = 2'd1;
        req.ar_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        req.w.data = 64'h5555_5555_5555_5555;
        req.w.strb = 8'hFF;
        req.w.last = 1'b0;
        req.w_valid = 1'b1;
        req.r_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_w_ready", 64'(rsp.w_ready), 0);
        chk("mid_rst_r_valid", 64'(rsp.r_valid), 0);
        chk("mid_rst_b_valid", 64'(rsp.b_valid), 0);
        chk("mid_rst_aw_ready", 64'(rsp.aw_ready), 0);
        chk("mid_rst_ar_ready", 64'(rsp.ar_ready), 0);
        req.w_valid = 1'b0;
        req.r_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_aw_ready", 64'(rsp.aw_ready), 1);
        chk("rel_ar_ready", 64'(rsp.ar_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("rel_no_b", 64'(rsp.b_valid), 0);
            chk("rel_no_r", 64'(rsp.r_valid), 0);
        end
        wd[0] = 64'h600DF00D_12345678;
        wst[0] = 8'hFF;
        do_write(48'h100, 8'd0, 3'd3, 2'd1, 6'd0, -1);
        do_read(48'h100, 8'd0, 3'd3, 2'd1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
